// File: rtl/nf_cpu_pkg.sv
// -----------------------------------------------------------------------------
// nf_cpu_pkg
// Shared definitions for the nf CPU control path: CSR address map, CSR
// command encodings and the read-modify-write helper used by the CSR file.
// -----------------------------------------------------------------------------
package nf_cpu_pkg;

  // CSR addresses (instruction bits [31:20])
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Low two bits of mtvec/mepc are hardwired to zero.
  localparam logic [31:0] CSR_ALIGN_MASK = 32'hFFFF_FFFC;

  // csr_cmd encodings as driven by the control unit
  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_WR   = 2'd1,
    CSR_SET  = 2'd2,
    CSR_CLR  = 2'd3
  } csr_cmd_e;

  // Next value of a CSR given its current value and the selected operand.
  function automatic logic [31:0] csr_alu(input csr_cmd_e    cmd,
                                          input logic [31:0] old_val,
                                          input logic [31:0] opnd);
    logic [31:0] res;
    res = old_val;
    case (cmd)
      CSR_WR:  res = opnd;
      CSR_SET: res = old_val | opnd;
      CSR_CLR: res = old_val & ~opnd;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nf_csr_cnt64.sv
// -----------------------------------------------------------------------------
// nf_csr_cnt64
// 64-bit free-running counter with increment enable and independent 32-bit
// half writes. A write to either half replaces that half, keeps the other
// and suppresses the increment for that cycle. The increment is a full
// 64-bit add, so the low-half carry reaches the high half in the same edge.
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - asynchronous active-high reset, clears the count
//   inc_i     - increment enable
//   wr_lo_i   - write wdata_i into bits [31:0]
//   wr_hi_i   - write wdata_i into bits [63:32]
//   wdata_i   - write data
//   cnt_o     - current count
// -----------------------------------------------------------------------------
module nf_csr_cnt64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/nf_csr.sv
// -----------------------------------------------------------------------------
// nf_csr
// Machine-mode CSR file for the nf RV32I core: misa, mtvec, mscratch, mepc,
// mcause, mcycle[h], minstret[h] and mhartid. Reads are combinational;
// writes (WR/SET/CLR read-modify-write) commit on the rising clock edge.
// Trap entry loads mepc/mcause and overrides a same-cycle CSR write to them.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   csr_addr   - CSR address
//   csr_zimm   - 5-bit zero-extended immediate operand
//   csr_rd1    - register-file operand
//   csr_sel    - 1: use zimm, 0: use rd1
//   csr_cmd    - NONE/WR/SET/CLR
//   csr_rreq   - read request (gates csr_rd)
//   csr_wreq   - write request
//   csr_rd     - read data (pre-write value)
//   csr_ill    - illegal access (unmapped, or write to read-only)
//   instr_ret  - instruction retired this cycle
//   trap       - trap entry pulse
//   trap_pc    - PC of trapping instruction
//   trap_cause - trap cause code
//   mtvec_v    - current mtvec
//   mepc_v     - current mepc
// -----------------------------------------------------------------------------
module nf_csr
  import nf_cpu_pkg::*;
#(
  parameter logic [31:0] MISA_V = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  csr_zimm,
  input  logic [31:0] csr_rd1,
  input  logic        csr_sel,
  input  logic [1:0]  csr_cmd,
  input  logic        csr_rreq,
  input  logic        csr_wreq,
  output logic [31:0] csr_rd,
  output logic        csr_ill,
  input  logic        instr_ret,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  output logic [31:0] mtvec_v,
  output logic [31:0] mepc_v
);

  csr_cmd_e cmd;
  assign cmd = csr_cmd_e'(csr_cmd);

  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  // Address decode and current value of the addressed CSR
  logic        hit;
  logic        ro;
  logic [31:0] cur_val;

  always_comb begin
    hit     = 1'b1;
    ro      = 1'b0;
    cur_val = '0;
    case (csr_addr)
      CSR_MISA: begin
        cur_val = MISA_V;
        ro      = 1'b1;
      end
      CSR_MTVEC:     cur_val = mtvec_q;
      CSR_MSCRATCH:  cur_val = mscratch_q;
      CSR_MEPC:      cur_val = mepc_q;
      CSR_MCAUSE:    cur_val = mcause_q;
      CSR_MCYCLE:    cur_val = mcycle[31:0];
      CSR_MCYCLEH:   cur_val = mcycle[63:32];
      CSR_MINSTRET:  cur_val = minstret[31:0];
      CSR_MINSTRETH: cur_val = minstret[63:32];
      CSR_MHARTID: begin
        cur_val = '0;
        ro      = 1'b1;
      end
      default: hit = 1'b0;
    endcase
  end

  logic        wr_attempt;
  logic        wr_en;
  logic [31:0] opnd;
  logic [31:0] wval;

  assign wr_attempt = csr_wreq && (cmd != CSR_NONE);
  assign wr_en      = wr_attempt && hit && !ro;
  assign opnd       = csr_sel ? {27'b0, csr_zimm} : csr_rd1;
  assign wval       = csr_alu(cmd, cur_val, opnd);

  assign csr_rd  = csr_rreq ? cur_val : '0;
  assign csr_ill = ((csr_rreq || csr_wreq) && !hit) || (wr_attempt && hit && ro);

  // Next state for the plain 32-bit CSRs
  always_comb begin
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (wr_en) begin
      case (csr_addr)
        CSR_MTVEC:    mtvec_d    = wval & CSR_ALIGN_MASK;
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval & CSR_ALIGN_MASK;
        CSR_MCAUSE:   mcause_d   = wval;
        default:      ;
      endcase
    end
    // Trap entry wins over a same-cycle software write to mepc/mcause.
    if (trap) begin
      mepc_d   = trap_pc & CSR_ALIGN_MASK;
      mcause_d = trap_cause;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  // Counter half-write strobes
  logic wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;

  assign wr_mcycle_lo   = wr_en && (csr_addr == CSR_MCYCLE);
  assign wr_mcycle_hi   = wr_en && (csr_addr == CSR_MCYCLEH);
  assign wr_minstret_lo = wr_en && (csr_addr == CSR_MINSTRET);
  assign wr_minstret_hi = wr_en && (csr_addr == CSR_MINSTRETH);

  nf_csr_cnt64 u_mcycle (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (1'b1),
    .wr_lo_i (wr_mcycle_lo),
    .wr_hi_i (wr_mcycle_hi),
    .wdata_i (wval),
    .cnt_o   (mcycle)
  );

  nf_csr_cnt64 u_minstret (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (instr_ret),
    .wr_lo_i (wr_minstret_lo),
    .wr_hi_i (wr_minstret_hi),
    .wdata_i (wval),
    .cnt_o   (minstret)
  );

  assign mtvec_v = mtvec_q;
  assign mepc_v  = mepc_q;

endmodule

// File: tb/tb_nf_csr.sv
// -----------------------------------------------------------------------------
// tb_nf_csr
// Directed testbench for nf_csr. Inputs change on the falling edge, outputs
// are sampled 1 ns later, and writes commit on the following rising edge.
// -----------------------------------------------------------------------------
module tb_nf_csr;

  localparam logic [31:0] MISA = 32'h4000_0100;
  localparam logic [1:0]  C_NONE = 2'd0;
  localparam logic [1:0]  C_WR   = 2'd1;
  localparam logic [1:0]  C_SET  = 2'd2;
  localparam logic [1:0]  C_CLR  = 2'd3;

  logic        clk;
  logic        reset;
  logic [11:0] csr_addr;
  logic [4:0]  csr_zimm;
  logic [31:0] csr_rd1;
  logic        csr_sel;
  logic [1:0]  csr_cmd;
  logic        csr_rreq;
  logic        csr_wreq;
  logic [31:0] csr_rd;
  logic        csr_ill;
  logic        instr_ret;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] mtvec_v;
  logic [31:0] mepc_v;

  int n_cmp;
  int n_fail;

  nf_csr #(.MISA_V(MISA)) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_addr   (csr_addr),
    .csr_zimm   (csr_zimm),
    .csr_rd1    (csr_rd1),
    .csr_sel    (csr_sel),
    .csr_cmd    (csr_cmd),
    .csr_rreq   (csr_rreq),
    .csr_wreq   (csr_wreq),
    .csr_rd     (csr_rd),
    .csr_ill    (csr_ill),
    .instr_ret  (instr_ret),
    .trap       (trap),
    .trap_pc    (trap_pc),
    .trap_cause (trap_cause),
    .mtvec_v    (mtvec_v),
    .mepc_v     (mepc_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of CSR stimulus at the falling edge; trap/instr_ret
  // default low and may be raised by the caller afterwards.
  task automatic drive(input logic [11:0] a, input logic [1:0] c, input logic s,
                       input logic [4:0] z, input logic [31:0] d,
                       input logic rr, input logic wr);
    @(negedge clk);
    csr_addr  = a;
    csr_cmd   = c;
    csr_sel   = s;
    csr_zimm  = z;
    csr_rd1   = d;
    csr_rreq  = rr;
    csr_wreq  = wr;
    trap      = 1'b0;
    instr_ret = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if (mtvec_v !== 32'h0 || mepc_v !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_vecs: got mtvec=%h mepc=%h want 0/0", mtvec_v, mepc_v);
    end
    csr_addr = 12'h301; csr_rreq = 1'b1; #1;
    n_cmp++;
    if (csr_rd !== MISA) begin
      n_fail++;
      $display("FAIL reset_misa: got %h want %h", csr_rd, MISA);
    end
    csr_addr = 12'hF14; #1;
    n_cmp++;
    if (csr_rd !== 32'h0 || csr_ill !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mhartid: got rd=%h ill=%b want 0/0", csr_rd, csr_ill);
    end
    csr_addr = 12'h301; csr_rreq = 1'b0; #1;
    n_cmp++;
    if (csr_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL no_rreq: got %h want 0", csr_rd);
    end
    @(negedge clk);
    reset = 1'b0; csr_addr = 12'hB00; csr_rreq = 1'b1; #1;
    n_cmp++;
    if (csr_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mcycle_at_release: got %h want 0", csr_rd);
    end
    drive(12'hB00, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'h1) begin
      n_fail++;
      $display("FAIL mcycle_first_edge: got %h want 1", csr_rd);
    end
  endtask

  task automatic test_mscratch;
    drive(12'h340, C_WR, 1'b0, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    n_cmp++;
    if (csr_rd !== 32'h0 || csr_ill !== 1'b0) begin
      n_fail++;
      $display("FAIL mscratch_prewrite: got rd=%h ill=%b want 0/0", csr_rd, csr_ill);
    end
    drive(12'h340, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL mscratch_read: got %h want deadbeef", csr_rd);
    end
  endtask

  task automatic test_mtvec_setclr;
    drive(12'h305, C_SET, 1'b1, 5'h1F, 32'hFFFF_FFFF, 1'b1, 1'b1);
    n_cmp++;
    if (csr_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mtvec_set_pre: got %h want 0", csr_rd);
    end
    drive(12'h305, C_CLR, 1'b1, 5'h1F, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (csr_rd !== 32'h1C || mtvec_v !== 32'h1C) begin
      n_fail++;
      $display("FAIL mtvec_after_set: got rd=%h v=%h want 1c", csr_rd, mtvec_v);
    end
    drive(12'h305, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mtvec_after_clr: got %h want 0", csr_rd);
    end
    drive(12'h305, C_WR, 1'b0, 5'd0, 32'h1234_5677, 1'b0, 1'b1);
    drive(12'h305, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'h1234_5674 || mtvec_v !== 32'h1234_5674) begin
      n_fail++;
      $display("FAIL mtvec_align: got rd=%h v=%h want 12345674", csr_rd, mtvec_v);
    end
  endtask

  task automatic test_mcycle_carry;
    drive(12'hB00, C_WR, 1'b0, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b1);
    drive(12'hB80, C_WR, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    drive(12'hB00, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL mcycle_suppress: got %h want fffffffe", csr_rd);
    end
    drive(12'hB00, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL mcycle_lo_max: got %h want ffffffff", csr_rd);
    end
    drive(12'hB00, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mcycle_lo_wrap: got %h want 0", csr_rd);
    end
    drive(12'hB80, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'h1) begin
      n_fail++;
      $display("FAIL mcycleh_carry: got %h want 1", csr_rd);
    end
  endtask

  task automatic test_trap;
    drive(12'h341, C_WR, 1'b0, 5'd0, 32'h55, 1'b1, 1'b1);
    trap = 1'b1; trap_pc = 32'h0000_0103; trap_cause = 32'd2;
    drive(12'h341, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'h100 || mepc_v !== 32'h100) begin
      n_fail++;
      $display("FAIL trap_mepc: got rd=%h v=%h want 100", csr_rd, mepc_v);
    end
    drive(12'h342, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'h2) begin
      n_fail++;
      $display("FAIL trap_mcause: got %h want 2", csr_rd);
    end
    drive(12'h341, C_WR, 1'b0, 5'd0, 32'h57, 1'b0, 1'b1);
    drive(12'h341, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'h54) begin
      n_fail++;
      $display("FAIL mepc_sw_write: got %h want 54", csr_rd);
    end
  endtask

  task automatic test_illegal;
    drive(12'h301, C_WR, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    n_cmp++;
    if (csr_ill !== 1'b1 || csr_rd !== MISA) begin
      n_fail++;
      $display("FAIL ill_misa_wr: got ill=%b rd=%h want 1/%h", csr_ill, csr_rd, MISA);
    end
    drive(12'h301, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_ill !== 1'b0 || csr_rd !== MISA) begin
      n_fail++;
      $display("FAIL misa_unchanged: got ill=%b rd=%h want 0/%h", csr_ill, csr_rd, MISA);
    end
    drive(12'h7C0, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_ill !== 1'b1 || csr_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL ill_unmapped_rd: got ill=%b rd=%h want 1/0", csr_ill, csr_rd);
    end
    drive(12'h7C0, C_SET, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    n_cmp++;
    if (csr_ill !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_unmapped_wr: got %b want 1", csr_ill);
    end
    drive(12'hF14, C_WR, 1'b0, 5'd0, 32'h1, 1'b1, 1'b1);
    n_cmp++;
    if (csr_ill !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_mhartid_wr: got %b want 1", csr_ill);
    end
    drive(12'h340, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'hDEAD_BEEF || csr_ill !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_state_kept: got rd=%h ill=%b want deadbeef/0", csr_rd, csr_ill);
    end
  endtask

  task automatic test_minstret;
    drive(12'hB02, C_WR, 1'b0, 5'd0, 32'd7, 1'b0, 1'b1);
    instr_ret = 1'b1;
    drive(12'hB02, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'd7) begin
      n_fail++;
      $display("FAIL minstret_suppress: got %0d want 7", csr_rd);
    end
    instr_ret = 1'b1;
    drive(12'hB02, C_NONE, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    drive(12'hB02, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'd8) begin
      n_fail++;
      $display("FAIL minstret_count: got %0d want 8", csr_rd);
    end
  endtask

  task automatic test_reset_mid_cycle;
    drive(12'hB02, C_WR, 1'b0, 5'd0, 32'd10, 1'b0, 1'b1);
    drive(12'hB02, C_NONE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (csr_rd !== 32'd10) begin
      n_fail++;
      $display("FAIL minstret_ten: got %0d want 10", csr_rd);
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (csr_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_minstret: got %0d want 0", csr_rd);
    end
    n_cmp++;
    if (mtvec_v !== 32'h0 || mepc_v !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_vecs: got mtvec=%h mepc=%h want 0/0", mtvec_v, mepc_v);
    end
    // Write and trap during reset must be discarded.
    drive(12'h340, C_WR, 1'b0, 5'd0, 32'h1111_1111, 1'b0, 1'b1);
    trap = 1'b1; trap_pc = 32'h200; trap_cause = 32'd5;
    @(negedge clk);
    trap = 1'b0; csr_wreq = 1'b0; csr_cmd = C_NONE;
    reset = 1'b0; csr_addr = 12'h340; csr_rreq = 1'b1;
    #1;
    n_cmp++;
    if (csr_rd !== 32'h0 || mepc_v !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_discard: got mscratch=%h mepc=%h want 0/0", csr_rd, mepc_v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    csr_addr = '0; csr_zimm = '0; csr_rd1 = '0; csr_sel = 1'b0;
    csr_cmd = C_NONE; csr_rreq = 1'b0; csr_wreq = 1'b0;
    instr_ret = 1'b0; trap = 1'b0; trap_pc = '0; trap_cause = '0;
    test_reset();
    test_mscratch();
    test_mtvec_setclr();
    test_mcycle_carry();
    test_trap();
    test_illegal();
    test_minstret();
    test_reset_mid_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nf_csr.md
NF_CSR -- requirements
Module: nf_csr

Interface
REQ-001 The module SHALL have parameter MISA_V, default 32'h4000_0100 (RV32I), the read-only misa value.
REQ-002 The module SHALL have clk  input  1  system clock, rising-edge active.
REQ-003 The module SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 The module SHALL have csr_addr  input  12  CSR address, instruction bits [31:20].
REQ-005 The module SHALL have csr_zimm  input  5  zero-extended immediate, rs1 field.
REQ-006 The module SHALL have csr_rd1  input  32  register-file operand.
REQ-007 The module SHALL have csr_sel  input  1  operand select: 1 selects zimm, 0 selects rd1.
REQ-008 The module SHALL have csr_cmd  input  2  command: NONE=0, WR=1, SET=2, CLR=3.
REQ-009 The module SHALL have csr_rreq  input  1  read request.
REQ-010 The module SHALL have csr_wreq  input  1  write request.
REQ-011 The module SHALL have csr_rd  output  32  read data.
REQ-012 The module SHALL have csr_ill  output  1  high when an access targets an unmapped address, or a write targets a read-only CSR.
REQ-013 The module SHALL have instr_ret  input  1  one instruction retired this cycle.
REQ-014 The module SHALL have trap  input  1  trap entry pulse.
REQ-015 The module SHALL have trap_pc  input  32  PC of the trapping instruction.
REQ-016 The module SHALL have trap_cause  input  32  cause code.
REQ-017 The module SHALL have mtvec_v  output  32  current mtvec.
REQ-018 The module SHALL have mepc_v  output  32  current mepc.

Function
REQ-019 The CSR address map SHALL be:
- misa 0x301, read-only
- mtvec 0x305
- mscratch 0x340
- mepc 0x341
- mcause 0x342
- mcycle 0xB00 and mcycleh 0xB80
- minstret 0xB02 and minstreth 0xB82
- mhartid 0xF14, read-only, returns 0
REQ-020 Read SHALL be combinational: csr_rd = current value of csr_addr when csr_rreq=1, else 0; an unmapped address SHALL read 0.
REQ-021 The operand SHALL be {27'b0,csr_zimm} when csr_sel=1, else csr_rd1.
REQ-022 The next value SHALL be: WR gives operand; SET gives old OR operand; CLR gives old AND NOT operand; NONE gives no write.
REQ-023 A write SHALL commit on the rising clk edge when csr_wreq=1 and csr_cmd!=NONE; csr_rd in the same cycle SHALL show the pre-write value.
REQ-024 Writes to read-only or unmapped CSRs SHALL be ignored and SHALL assert csr_ill combinationally.
REQ-025 mtvec[1:0] and mepc[1:0] SHALL always read 0.
REQ-026 mcycle (64-bit) SHALL increment every cycle out of reset and wrap from 2^64-1 to 0.
REQ-027 minstret (64-bit) SHALL increment when instr_ret=1 and wrap the same way.
REQ-028 A write to the low or high half of a counter SHALL replace that half, keep the other half, and suppress that counter's increment in that cycle.
REQ-029 A low-half increment from 32'hFFFF_FFFF SHALL carry into the high half in the same cycle.
REQ-030 On trap=1, mepc SHALL be set to {trap_pc[31:2],2'b00} and mcause to trap_cause at the next edge.
REQ-031 trap SHALL take priority over a simultaneous CSR write to mepc or mcause; writes to other CSRs in the same cycle SHALL still commit.
REQ-032 mtvec_v and mepc_v SHALL reflect register contents with zero added latency.

Reset
REQ-033 On reset assertion, all writable CSRs and counters SHALL clear to 0 immediately, independent of clk.
REQ-034 During reset, csr_rd SHALL be 0 (or misa/mhartid if addressed), csr_ill SHALL follow its combinational definition, and mtvec_v and mepc_v SHALL be 0.
REQ-035 A write or trap coincident with reset SHALL be discarded.
REQ-036 Counters SHALL start incrementing on the first edge after reset deassertion.

Structure
REQ-037 The CSR address constants and the csr_cmd encodings (CSR_NONE, CSR_WR, CSR_SET, CSR_CLR) SHALL live in the shared nf_cpu package/header used by the control unit.
REQ-038 One sub-module, nf_csr_cnt64, SHALL be instantiated twice for mcycle and minstret, providing 64-bit counting with enable, half-word write and carry.

Verification
REQ-039 The bench SHALL cover: csrrw mscratch with rd1=32'hDEAD_BEEF -> csr_rd=0 that cycle; a next-cycle read returns DEADBEEF.
REQ-040 The bench SHALL cover: csrrs then csrrc on mtvec with zimm=5'h1F starting from 0 -> reads 32'h1C, then 0; bits [1:0] stay 0.
REQ-041 The bench SHALL cover: write mcycle=32'hFFFF_FFFE, mcycleh=0 -> two cycles later {mcycleh,mcycle}=64'h1_0000_0000.
REQ-042 The bench SHALL cover: trap with trap_pc=32'h0000_0103, cause=2, plus a simultaneous csrrw mepc=0x55 -> mepc=0x100, mcause=2.
REQ-043 The bench SHALL cover: write 0x301 or access 0x7C0 -> csr_ill=1, state unchanged, read 0x7C0 returns 0.
REQ-044 The bench SHALL cover: reset asserted mid-cycle while minstret=10 -> minstret=0 without a clk edge.
